// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight selectable operations with zero/negative/parity
// flags, carried through a STAGES-deep valid/ready pipeline with full backpressure.
module logic_unit_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_parity
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASB = 3'b111
    } op_e;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] zero_q, zero_d;
    logic [STAGES-1:0] neg_q, neg_d;
    logic [STAGES-1:0] par_q, par_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  alu_res;

    always_comb begin
        alu_res = '0;
        case (op_e'(op))
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NAND: alu_res = ~(a & b);
            OP_NOR:  alu_res = ~(a | b);
            OP_XNOR: alu_res = ~(a ^ b);
            OP_NOTA: alu_res = ~a;
            OP_PASB: alu_res = b;
            default: alu_res = '0;
        endcase
    end

    // Stage i may load when any stage from i to the output has a hole, or the
    // output is being consumed; accumulated from the output end to avoid a
    // self-referencing ready chain.
    always_comb begin
        logic acc;
        load = '0;
        acc  = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            acc                = acc | ~valid_q[STAGES-1-k];
            load[STAGES-1-k]   = acc;
        end
    end

    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        par_d   = par_q;
        res_d   = res_q;
        if (load[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                res_d[0]  = alu_res;
                zero_d[0] = ~|alu_res;
                neg_d[0]  = alu_res[WIDTH-1];
                par_d[0]  = ^alu_res;
            end
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    res_d[i]  = res_q[i-1];
                    zero_d[i] = zero_q[i-1];
                    neg_d[i]  = neg_q[i-1];
                    par_d[i]  = par_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            zero_q  <= '0;
            neg_q   <= '0;
            par_q   <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            par_q   <= par_d;
            for (int unsigned i = 0; i < STAGES; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    assign in_ready    = rst & load[0];
    assign out_valid   = valid_q[STAGES-1];
    assign result      = res_q[STAGES-1];
    assign flag_zero   = zero_q[STAGES-1];
    assign flag_neg    = neg_q[STAGES-1];
    assign flag_parity = par_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps on a 16-bit/2-stage and an
// 8-bit/1-stage instance, then randomized traffic against a queue-based reference.
module tb_logic_unit_pipe;

    logic clk;
    logic rst;

    // 16-bit, 2-stage instance
    logic        p16_in_valid, p16_in_ready, p16_out_valid, p16_out_ready;
    logic [2:0]  p16_op;
    logic [15:0] p16_a, p16_b, p16_result;
    logic        p16_zero, p16_neg, p16_par;

    // 8-bit, 1-stage instance
    logic        p8_in_valid, p8_in_ready, p8_out_valid, p8_out_ready;
    logic [2:0]  p8_op;
    logic [7:0]  p8_a, p8_b, p8_result;
    logic        p8_zero, p8_neg, p8_par;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic        n;
        logic        p;
    } exp_t;

    exp_t q[$];

    logic_unit_pipe #(.WIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(p16_in_valid), .in_ready(p16_in_ready),
        .op(p16_op), .a(p16_a), .b(p16_b),
        .out_valid(p16_out_valid), .out_ready(p16_out_ready),
        .result(p16_result), .flag_zero(p16_zero), .flag_neg(p16_neg),
        .flag_parity(p16_par)
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(p8_in_valid), .in_ready(p8_in_ready),
        .op(p8_op), .a(p8_a), .b(p8_b),
        .out_valid(p8_out_valid), .out_ready(p8_out_ready),
        .result(p8_result), .flag_zero(p8_zero), .flag_neg(p8_neg),
        .flag_parity(p8_par)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference: operation table on plain integers, masked to the operand width.
    function automatic logic [63:0] ref_op(input int o, input logic [63:0] x,
                                           input logic [63:0] y, input int w);
        logic [63:0] r;
        logic [63:0] mask;
        case (o)
            0: r = x & y;
            1: r = x | y;
            2: r = x ^ y;
            3: r = ~(x & y);
            4: r = ~(x | y);
            5: r = ~(x ^ y);
            6: r = ~x;
            default: r = y;
        endcase
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return r & mask;
    endfunction

    function automatic exp_t ref16(input int o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        logic [63:0] r;
        r   = ref_op(o, {48'd0, x}, {48'd0, y}, 16);
        e.r = r[15:0];
        e.z = (r == 64'd0);
        e.n = (r >= 64'h8000);
        e.p = ($countones(r) % 2) == 1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input exp_t e);
        chk({tag, "_valid"}, {63'd0, p16_out_valid}, 64'd1);
        chk({tag, "_res"},   {48'd0, p16_result}, {48'd0, e.r});
        chk({tag, "_zero"},  {63'd0, p16_zero}, {63'd0, e.z});
        chk({tag, "_neg"},   {63'd0, p16_neg},  {63'd0, e.n});
        chk({tag, "_par"},   {63'd0, p16_par},  {63'd0, e.p});
    endtask

    task automatic drv16(input logic v, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y);
        p16_in_valid = v;
        p16_op       = o;
        p16_a        = x;
        p16_b        = y;
    endtask

    initial begin
        exp_t e;
        bit   mrdy;
        bit   push;
        bit   pop;
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        drv16(1'b0, 3'd0, 16'h0, 16'h0);
        p16_out_ready = 1'b1;
        p8_in_valid = 1'b0; p8_op = 3'd0; p8_a = 8'h0; p8_b = 8'h0;
        p8_out_ready = 1'b1;

        // Reset state
        #5;
        chk("rst_out_valid", {63'd0, p16_out_valid}, 64'd0);
        chk("rst_result",    {48'd0, p16_result}, 64'd0);
        chk("rst_flags",     {61'd0, p16_zero, p16_neg, p16_par}, 64'd0);
        chk("rst_in_ready",  {63'd0, p16_in_ready}, 64'd0);
        chk("rst8_in_ready", {63'd0, p8_in_ready}, 64'd0);
        #10 rst = 1'b1;
        #1;
        chk("rel_in_ready",  {63'd0, p16_in_ready}, 64'd1);
        chk("rel8_in_ready", {63'd0, p8_in_ready}, 64'd1);

        // Basic XOR, two-cycle latency
        drv16(1'b1, 3'b010, 16'h000B, 16'h000D);
        #1;
        chk("xor_in_ready", {63'd0, p16_in_ready}, 64'd1);
        step();
        p16_in_valid = 1'b0;
        chk("xor_lat_early", {63'd0, p16_out_valid}, 64'd0);
        step();
        e.r = 16'h0006; e.z = 1'b0; e.n = 1'b0; e.p = 1'b0;
        chk16("xor", e);
        step();
        chk("xor_gone", {63'd0, p16_out_valid}, 64'd0);

        // Back-to-back ops
        drv16(1'b1, 3'b000, 16'hF00F, 16'h0FF0);
        step();
        drv16(1'b1, 3'b001, 16'hF00F, 16'h0FF0);
        step();
        e.r = 16'h0000; e.z = 1'b1; e.n = 1'b0; e.p = 1'b0;
        chk16("b2b_and", e);
        drv16(1'b1, 3'b110, 16'h0001, 16'h1234);
        step();
        e.r = 16'hFFFF; e.z = 1'b0; e.n = 1'b1; e.p = 1'b0;
        chk16("b2b_or", e);
        p16_in_valid = 1'b0;
        step();
        e.r = 16'hFFFE; e.z = 1'b0; e.n = 1'b1; e.p = 1'b1;
        chk16("b2b_nota", e);
        step();
        chk("b2b_gone", {63'd0, p16_out_valid}, 64'd0);

        // Backpressure: fills after two, holds, then drains in order
        p16_out_ready = 1'b0;
        drv16(1'b1, 3'b010, 16'h1234, 16'h00FF);
        #1;
        chk("bp_rdy1", {63'd0, p16_in_ready}, 64'd1);
        step();
        drv16(1'b1, 3'b010, 16'hAAAA, 16'h5555);
        chk("bp_rdy2", {63'd0, p16_in_ready}, 64'd1);
        step();
        drv16(1'b1, 3'b010, 16'h0F0F, 16'h0F0F);
        #1;
        chk("bp_full", {63'd0, p16_in_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            e.r = 16'h12CB; e.z = 1'b0; e.n = 1'b0; e.p = 1'b1;
            chk16("bp_hold", e);
            chk("bp_hold_rdy", {63'd0, p16_in_ready}, 64'd0);
        end
        p16_out_ready = 1'b1;
        #1;
        chk("bp_rdy_same_cycle", {63'd0, p16_in_ready}, 64'd1);
        step();
        p16_in_valid = 1'b0;
        e.r = 16'hFFFF; e.z = 1'b0; e.n = 1'b1; e.p = 1'b0;
        chk16("bp_second", e);
        step();
        e.r = 16'h0000; e.z = 1'b1; e.n = 1'b0; e.p = 1'b0;
        chk16("bp_third", e);
        step();
        chk("bp_no_dup", {63'd0, p16_out_valid}, 64'd0);

        // 8-bit, single-stage instance
        p8_in_valid = 1'b1; p8_op = 3'b101; p8_a = 8'hAA; p8_b = 8'h55;
        #1;
        chk("w8_in_ready", {63'd0, p8_in_ready}, 64'd1);
        step();
        p8_op = 3'b111; p8_a = 8'h3C; p8_b = 8'h81;
        chk("w8_xnor_valid", {63'd0, p8_out_valid}, 64'd1);
        chk("w8_xnor_res",   {56'd0, p8_result}, 64'h00);
        chk("w8_xnor_flags", {61'd0, p8_zero, p8_neg, p8_par}, 64'b100);
        step();
        p8_in_valid = 1'b0;
        chk("w8_pasb_valid", {63'd0, p8_out_valid}, 64'd1);
        chk("w8_pasb_res",   {56'd0, p8_result}, 64'h81);
        chk("w8_pasb_flags", {61'd0, p8_zero, p8_neg, p8_par}, 64'b010);
        step();
        chk("w8_gone", {63'd0, p8_out_valid}, 64'd0);

        // Reset mid-stream
        p16_out_ready = 1'b0;
        drv16(1'b1, 3'b001, 16'h00F0, 16'h0F00);
        step();
        drv16(1'b1, 3'b011, 16'hFFFF, 16'h0001);
        step();
        p16_in_valid = 1'b0;
        chk("mid_pre_valid", {63'd0, p16_out_valid}, 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("mid_async_valid", {63'd0, p16_out_valid}, 64'd0);
        chk("mid_async_res",   {48'd0, p16_result}, 64'd0);
        chk("mid_async_rdy",   {63'd0, p16_in_ready}, 64'd0);
        #2 rst = 1'b1;
        p16_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mid_no_stale", {63'd0, p16_out_valid}, 64'd0);
        end

        // Randomized traffic against the queue reference
        q.delete();
        for (int i = 0; i < 400; i++) begin
            drv16(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  16'($urandom), 16'($urandom));
            p16_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            mrdy = (q.size() < 2) || p16_out_ready;
            chk("rnd_in_ready", {63'd0, p16_in_ready}, {63'd0, mrdy});
            if (p16_out_valid) begin
                chk("rnd_have_entry", {63'd0, (q.size() != 0)}, 64'd1);
                if (q.size() != 0) chk16("rnd", q[0]);
            end
            pop  = p16_out_valid && p16_out_ready && (q.size() != 0);
            push = p16_in_valid && mrdy;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ref16(int'(p16_op), p16_a, p16_b));
            @(posedge clk);
            #1;
        end

        // Drain with bounded wait
        p16_in_valid  = 1'b0;
        p16_out_ready = 1'b1;
        #1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            if (p16_out_valid) begin
                chk16("drain", q[0]);
                void'(q.pop_front());
            end
            step();
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_idle", {63'd0, p16_out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined logical-operation unit for the ALU LOGICALOPERATIONS group; supersedes the single-function registered 16-bit logic cells.
- Performs one of eight bitwise operations per transaction, selected per transaction, on WIDTH-bit operands.
- Carries results through a STAGES-deep valid/ready pipeline with full backpressure.
- Produces zero, negative and parity flags alongside each result for the ALU flag logic.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 1..64.
- STAGES, 2, pipeline depth in register stages; legal range 1..8; also the no-stall latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream asserts when op/a/b are valid.
- in_ready  output  1  block can accept a transaction this cycle.
- op  input  3  operation select, sampled on accept.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts the result this cycle.
- result  output  WIDTH  operation result.
- flag_zero  output  1  result == 0.
- flag_neg  output  1  result[WIDTH-1].
- flag_parity  output  1  XOR-reduction of result; 1 = odd number of ones.

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND.
  - 100 NOR, 101 XNOR, 110 NOT A (b ignored), 111 PASS B (a ignored).
  - All codes legal; no error output.
- Accept: a transaction is accepted on a rising edge where in_valid && in_ready.
  - The result is computed combinationally from the inputs and captured with its flags into stage 0.
  - Stages 1..STAGES-1 carry result, flags and a valid bit.
- Stall rule per stage i:
  - The stage loads when it is empty or when stage i+1 loads/empties this cycle.
  - The last stage empties when out_valid && out_ready.
  - in_ready = stage-0 load condition, i.e. !valid[0] || stage 0 advancing.
  - Ready propagates combinationally from out_ready to in_ready.
  - No bubbles are inserted; throughput is 1 transaction/cycle while out_ready is held high.
- Latency: a transaction accepted at edge N appears on out_valid/result after edge N+STAGES-1, i.e. visible in cycle N+STAGES with no stall. With STAGES=1, output is registered one cycle after accept.
- Capacity: STAGES transactions in flight. With out_ready=0, in_ready deasserts once all stages are valid.
- Output stability: while out_valid=1 and out_ready=0, result and flags are held constant; no transaction is dropped or duplicated.
- Ordering: results exit strictly in acceptance order.
- Flags: computed from the WIDTH-bit result at stage 0 and carried unchanged through the pipeline. flag_neg uses bit WIDTH-1; for WIDTH=1, flag_neg = result[0].
- Simultaneous events: a pop (out_ready) and a push (in_valid) in the same cycle on a full pipeline are both honoured; occupancy is unchanged.
- Reset (rst low, asynchronous):
  - Clears all stage valid bits, result registers and flags to 0 immediately, including mid-stream.
  - Outputs are out_valid=0, result=0, all flags=0.
  - in_ready=0 while rst low; in_ready=1 in the first cycle after release.
  - In-flight transactions are discarded and never emerge.
- Inputs op/a/b are don't-care when in_valid=0.

Test Plan:
- Reset: rst=0 for 15 ns with clk period 10 ns → out_valid=0, result=0x0000, flags=0, in_ready=0; after release → in_ready=1.
- Basic XOR (WIDTH=16, STAGES=2, out_ready=1): op=010, a=0x000B, b=0x000D → out_valid 2 cycles after accept; result=0x0006, zero=0, neg=0, parity=0.
- Back-to-back ops, one per cycle, out_ready=1:
  - AND 0xF00F,0x0FF0 → 0x0000, zero=1.
  - OR same operands → 0xFFFF, neg=1, parity=0.
  - NOT A with a=0x0001 → 0xFFFE, parity=1.
  - Results appear on consecutive cycles in order.
- Backpressure: out_ready=0, offer 3 XOR transactions → 2 accepted, then in_ready=0; result held at the first value for 5 cycles. Then out_ready=1 → 3 results in order, no duplicates; in_ready reasserts the same cycle.
- Reset mid-stream: 2 transactions in flight, pulse rst low mid-cycle → out_valid drops immediately (before the next edge); after release, no stale results appear within 10 cycles.
- WIDTH=8, STAGES=1: XNOR 0xAA,0x55 → result 0x00, zero=1, latency 1 cycle; PASS B b=0x81 → 0x81, neg=1, parity=0.
